// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register plus writeback for the 5-stage RV32I core.
// Latches the MEM-stage result. Formats load data by byte/half lane and sign or zero
// extension. Picks the writeback source and drives the register-file write port directly.
// Also keeps the retired-instruction counter.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   stall, flush          hold stage / insert bubble (flush wins)
//   in_valid, in_regWr    MEM-stage instruction valid / writes rd
//   in_rd                 destination register
//   in_wb_sel             00 ALU, 01 load, 10 PC+4, 11 treated as ALU
//   in_funct3             load size/sign
//   in_alu_result         ALU result, also the load byte address
//   in_mem_rdata          word-aligned data-memory read word
//   in_pc_plus4           link value for JAL/JALR
//   regWr, ws, wr_data    register-file write port
//   wb_valid              WB slot holds a valid instruction
//   misalign_err          WB load is misaligned (its write is suppressed)
//   instret               retired-instruction count, wraps
module mem_wb_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic               in_regWr,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [1:0]         in_wb_sel,
  input  logic [2:0]         in_funct3,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [XLEN-1:0]    in_mem_rdata,
  input  logic [XLEN-1:0]    in_pc_plus4,
  output logic               regWr,
  output logic [RADDR_W-1:0] ws,
  output logic [XLEN-1:0]    wr_data,
  output logic               wb_valid,
  output logic               misalign_err,
  output logic [CNT_W-1:0]   instret
);

  localparam logic [1:0] SelAlu  = 2'b00;
  localparam logic [1:0] SelLoad = 2'b01;
  localparam logic [1:0] SelPc4  = 2'b10;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  logic               valid_q;
  logic               regwr_q;
  logic [RADDR_W-1:0] rd_q;
  logic [1:0]         wb_sel_q;
  logic [2:0]         funct3_q;
  logic [XLEN-1:0]    alu_q;
  logic [XLEN-1:0]    rdata_q;
  logic [XLEN-1:0]    pc4_q;
  logic [CNT_W-1:0]   instret_q;

  logic [1:0]         off;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [XLEN-1:0]    load_data;
  logic               retire;

  // Stage registers. A flush only needs to kill valid and the write enable;
  // the remaining fields are left as they are.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      regwr_q  <= 1'b0;
      rd_q     <= '0;
      wb_sel_q <= '0;
      funct3_q <= '0;
      alu_q    <= '0;
      rdata_q  <= '0;
      pc4_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
    end else if (!stall) begin
      valid_q  <= in_valid;
      regwr_q  <= in_regWr;
      rd_q     <= in_rd;
      wb_sel_q <= in_wb_sel;
      funct3_q <= in_funct3;
      alu_q    <= in_alu_result;
      rdata_q  <= in_mem_rdata;
      pc4_q    <= in_pc_plus4;
    end
  end

  // The instruction in WB retires when it leaves the slot. That happens on a normal
  // advance or on a flush. A stalled instruction stays put, so it is counted only once.
  assign retire = valid_q & ~misalign_err & (~stall | flush);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Load lane selection and extension.
  always_comb begin
    off = alu_q[1:0];
    byte_sel = 8'h00;
    unique case (off)
      2'd0: byte_sel = rdata_q[7:0];
      2'd1: byte_sel = rdata_q[15:8];
      2'd2: byte_sel = rdata_q[23:16];
      2'd3: byte_sel = rdata_q[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (funct3_q)
      F3Lb:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3Lbu:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3Lh:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3Lhu:   load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = rdata_q;  // LW and the reserved encodings
    endcase
  end

  always_comb begin
    misalign_err = 1'b0;
    if (valid_q && (wb_sel_q == SelLoad)) begin
      if ((funct3_q == F3Lh) || (funct3_q == F3Lhu)) begin
        misalign_err = off[0];
      end else if (funct3_q == F3Lw) begin
        misalign_err = (off != 2'd0);
      end
    end
  end

  always_comb begin
    wr_data = '0;
    if (valid_q) begin
      unique case (wb_sel_q)
        SelLoad: wr_data = load_data;
        SelPc4:  wr_data = pc4_q;
        SelAlu:  wr_data = alu_q;
        default: wr_data = alu_q;
      endcase
    end
  end

  assign regWr    = valid_q & regwr_q & (rd_q != '0) & ~misalign_err;
  assign ws       = rd_q;
  assign wb_valid = valid_q;
  assign instret  = instret_q;

endmodule
